// File: rtl/mux4_sched_pkg.sv
// Shared types and constants for the four-way round-robin mux scheduler.
package mux4_sched_pkg;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // One-hot grant vector for an encoded owner index.
   function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      return NUM_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/mux4_rr_sched_rr_pick4.sv
// Combinational four-way round-robin picker: rotate the request vector so the
// pointer position sits at bit 0, take the lowest set bit, then rotate the
// index back. When MUX4_SCHED_PRIO0_EN is defined, requester 0 always wins
// and the round-robin scan covers requesters 1..3 only.
module rr_pick4
   import mux4_sched_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [SEL_W-1:0]   ptr_i,
   output logic               any_o,
   output logic [SEL_W-1:0]   idx_o
);

   logic [NUM_REQ-1:0]   req_eff;
   logic [2*NUM_REQ-1:0] req_dbl;
   logic [NUM_REQ-1:0]   req_rot;
   logic [SEL_W-1:0]     offset;
   logic                 found;

   // Rotate, priority-encode, un-rotate, then apply the optional fixed priority.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves
      // a value unassigned, which would otherwise infer a latch.
      req_eff = req_i;
      offset  = '0;
      found   = 1'b0;
`ifdef MUX4_SCHED_PRIO0_EN
      req_eff[0] = 1'b0;
`endif
      req_dbl = {req_eff, req_eff};
      req_rot = req_dbl[ptr_i +: NUM_REQ];
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_rot[i] && !found) begin
            offset = SEL_W'(i);
            found  = 1'b1;
         end
      end
      idx_o = ptr_i + offset;
`ifdef MUX4_SCHED_PRIO0_EN
      if (req_i[0]) begin
         idx_o = '0;
      end
`endif
      any_o = |req_i;
   end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler in front of a shared 4:1 mux. One owner is granted at a
// time and keeps the select lines stable for up to MAX_BURST accepted transfers
// or until it drops its request; a one-cycle IDLE bubble separates owners.
// Optional build macro: MUX4_SCHED_PRIO0_EN (requester 0 fixed high priority).
module mux4_rr_sched
   import mux4_sched_pkg::*;
#(
   parameter int DATA_W    = 1,
   parameter int MAX_BURST = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ*DATA_W-1:0] data_i,
   input  logic                      out_ready_i,
   output logic [NUM_REQ-1:0]        gnt_o,
   output logic [SEL_W-1:0]          sel_o,
   output logic                      out_valid_o,
   output logic [DATA_W-1:0]         out_data_o,
   output logic                      busy_o
);

   localparam int               CNT_W     = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

   state_t             state_q;
   logic [NUM_REQ-1:0] gnt_q;
   logic [SEL_W-1:0]   sel_q;
   logic [SEL_W-1:0]   ptr_q;
   logic [CNT_W-1:0]   burst_cnt_q;

   logic               pick_any;
   logic [SEL_W-1:0]   pick_idx;
   logic               owner_req;
   logic               xfer;
   logic               release_now;

   rr_pick4 u_pick (
      .req_i (req_i),
      .ptr_i (ptr_q),
      .any_o (pick_any),
      .idx_o (pick_idx)
   );

   // Datapath follows the registered select; valid is the owner's live request.
   assign owner_req   = req_i[sel_q];
   assign busy_o      = (state_q == GRANT);
   assign out_valid_o = busy_o & owner_req;
   assign xfer        = out_valid_o & out_ready_i;
   assign out_data_o  = data_i[sel_q*DATA_W +: DATA_W];
   assign gnt_o       = gnt_q;
   assign sel_o       = sel_q;

   // Owner gives up the grant by dropping its request or by finishing a full burst.
   assign release_now = !owner_req || (xfer && (burst_cnt_q == LAST_BEAT));

   // Arbitration FSM: grant on IDLE->GRANT, release and advance pointer on GRANT->IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         sel_q       <= '0;
         ptr_q       <= '0;
         burst_cnt_q <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every register
         // samples the pre-edge values regardless of statement order.
         case (state_q)
            IDLE: begin
               if (pick_any) begin
                  gnt_q       <= onehot(pick_idx);
                  sel_q       <= pick_idx;
                  burst_cnt_q <= '0;
                  state_q     <= GRANT;
               end
            end
            GRANT: begin
               if (release_now) begin
                  gnt_q       <= '0;
                  ptr_q       <= sel_q + 1'b1;
                  burst_cnt_q <= '0;
                  state_q     <= IDLE;
               end else if (xfer) begin
                  burst_cnt_q <= burst_cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Self-checking bench for mux4_rr_sched: directed scenarios plus a random run,
// each compared against a transaction-level owner/ptr/count model.
module tb_mux4_rr_sched;

   localparam int DW = 8;
   localparam int MB = 4;
   localparam int VW = 8 + DW;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [3:0]      req_i = '0;
   logic [4*DW-1:0] data_i = '0;
   logic            out_ready_i = 1'b0;
   logic [3:0]      gnt_o;
   logic [1:0]      sel_o;
   logic            out_valid_o;
   logic [DW-1:0]   out_data_o;
   logic            busy_o;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: who owns the mux, how many beats it has moved, where the scan starts.
   bit m_busy;
   int m_sel;
   int m_ptr;
   int m_cnt;

   mux4_rr_sched #(.DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_i       (req_i),
      .data_i      (data_i),
      .out_ready_i (out_ready_i),
      .gnt_o       (gnt_o),
      .sel_o       (sel_o),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   function automatic int model_pick(input logic [3:0] r, input int p);
`ifdef MUX4_SCHED_PRIO0_EN
      if (r[0]) return 0;
      r[0] = 1'b0;
`endif
      for (int k = 0; k < 4; k++) begin
         if (r[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_busy = 1'b0;
      m_sel  = 0;
      m_ptr  = 0;
      m_cnt  = 0;
   endtask

   task automatic model_edge();
      if (rst) return;
      if (!m_busy) begin
         if (req_i != 4'b0) begin
            m_sel  = model_pick(req_i, m_ptr);
            m_busy = 1'b1;
            m_cnt  = 0;
         end
      end else if (!req_i[m_sel]) begin
         m_busy = 1'b0;
         m_ptr  = (m_sel + 1) % 4;
      end else if (out_ready_i) begin
         m_cnt++;
         if (m_cnt == MB) begin
            m_busy = 1'b0;
            m_ptr  = (m_sel + 1) % 4;
         end
      end
   endtask

   function automatic logic [VW-1:0] exp_vec();
      logic [3:0] g;
      logic       v;
      g = m_busy ? 4'(1 << m_sel) : 4'b0;
      v = m_busy && req_i[m_sel];
      return {g, 2'(m_sel), v, m_busy, data_i[m_sel*DW +: DW]};
   endfunction

   function automatic logic [VW-1:0] obs_vec();
      return {gnt_o, sel_o, out_valid_o, busy_o, out_data_o};
   endfunction

   // Advance one clock: model follows the edge, then return to the falling edge.
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      req_i = '0;
      data_i = $urandom;
      #2 rst = 1'b1;
      model_reset();
      #1;
      n_vec++;
      if (gnt_o !== 4'b0 || sel_o !== 2'b0 || out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_async: got gnt=%b sel=%0d valid=%b busy=%b, want 0000/0/0/0",
                  gnt_o, sel_o, out_valid_o, busy_o);
      end
      n_vec++;
      if (out_data_o !== data_i[DW-1:0]) begin
         n_err++;
         $display("FAIL reset_data: got %h want %h", out_data_o, data_i[DW-1:0]);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         data_i = $urandom;
         #1;
         n_vec++;
         if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_idle c%0d: got %h want %h", c, obs_vec(), exp_vec());
         end
         tick();
      end
   endtask

   task automatic test_rotation();
      int starts[$];
      int counts[$];
      int gaps[$];
      int cur  = 0;
      int idle = 0;
      bit prev = 1'b0;
      int exp_order[5] = '{0, 1, 2, 3, 0};
      apply_reset();
      req_i = 4'b1111;
      out_ready_i = 1'b1;
      for (int c = 0; c < 26; c++) begin
         data_i = $urandom;
         #1;
         n_vec++;
         if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL rotation c%0d: got %h want %h", c, obs_vec(), exp_vec());
         end
         if (busy_o && !prev) begin
            if (starts.size() > 0) gaps.push_back(idle);
            starts.push_back(int'(sel_o));
            idle = 0;
         end
         if (!busy_o && prev) begin
            counts.push_back(cur);
            cur = 0;
         end
         if (busy_o && out_valid_o && out_ready_i) cur++;
         if (!busy_o) idle++;
         prev = busy_o;
         tick();
      end
      n_vec++;
      if (starts.size() != 5 || counts.size() != 5 || gaps.size() != 4) begin
         n_err++;
         $display("FAIL rotation_shape: got grants=%0d bursts=%0d gaps=%0d want 5/5/4",
                  starts.size(), counts.size(), gaps.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (starts[i] != exp_order[i] || counts[i] != MB) begin
               n_err++;
               $display("FAIL rotation_grant%0d: got owner=%0d xfers=%0d want %0d/%0d",
                        i, starts[i], counts[i], exp_order[i], MB);
            end
         end
         for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (gaps[i] != 1) begin
               n_err++;
               $display("FAIL rotation_bubble%0d: got %0d idle cycles want 1", i, gaps[i]);
            end
         end
      end
   endtask

   task automatic test_early_release();
      logic [3:0] reqs[6] = '{4'b0100, 4'b1101, 4'b1101, 4'b1001, 4'b1001, 4'b1001};
      apply_reset();
      out_ready_i = 1'b1;
      for (int c = 0; c < 6; c++) begin
         req_i  = reqs[c];
         data_i = $urandom;
         #1;
         n_vec++;
         if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL early_release c%0d: got %h want %h", c, obs_vec(), exp_vec());
         end
         if (c == 3) begin
            n_vec++;
            if (out_valid_o !== 1'b0 || gnt_o !== 4'b0100) begin
               n_err++;
               $display("FAIL early_drop: got valid=%b gnt=%b want 0/0100", out_valid_o, gnt_o);
            end
         end
         if (c == 4) begin
            n_vec++;
            if (gnt_o !== 4'b0 || busy_o !== 1'b0) begin
               n_err++;
               $display("FAIL early_bubble: got gnt=%b busy=%b want 0000/0", gnt_o, busy_o);
            end
         end
         if (c == 5) begin
            n_vec++;
            if (gnt_o !== 4'b1000 || sel_o !== 2'd3) begin
               n_err++;
               $display("FAIL early_next: got gnt=%b sel=%0d want 1000/3", gnt_o, sel_o);
            end
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      int xf     = 0;
      int rel_at = -1;
      bit regrant = 1'b0;
      apply_reset();
      req_i = 4'b0010;
      out_ready_i = 1'b0;
      #1;
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
         n_err++;
         $display("FAIL bp_start: got %h want %h", obs_vec(), exp_vec());
      end
      tick();
      for (int c = 0; c < 10; c++) begin
         data_i = $urandom;
         #1;
         n_vec++;
         if (gnt_o !== 4'b0010 || out_data_o !== data_i[DW +: DW] || obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL bp_hold c%0d: got %h want %h", c, obs_vec(), exp_vec());
         end
         tick();
      end
      out_ready_i = 1'b1;
      for (int c = 0; c < 8; c++) begin
         data_i = $urandom;
         #1;
         n_vec++;
         if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL bp_drain c%0d: got %h want %h", c, obs_vec(), exp_vec());
         end
         if (rel_at < 0 && !busy_o) rel_at = c;
         if (rel_at < 0 && out_valid_o && out_ready_i) xf++;
         if (c == 5 && busy_o && sel_o == 2'd1) regrant = 1'b1;
         tick();
      end
      n_vec++;
      if (xf != MB || rel_at != MB || !regrant) begin
         n_err++;
         $display("FAIL bp_burst: got xfers=%0d release_cycle=%0d regrant=%b want %0d/%0d/1",
                  xf, rel_at, regrant, MB, MB);
      end
   endtask

   task automatic test_reset_mid_burst();
      apply_reset();
      req_i = 4'b1111;
      out_ready_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         data_i = $urandom;
         #1;
         n_vec++;
         if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL midrst_pre c%0d: got %h want %h", c, obs_vec(), exp_vec());
         end
         tick();
      end
      #2 rst = 1'b1;
      model_reset();
      #1;
      n_vec++;
      if (gnt_o !== 4'b0 || busy_o !== 1'b0 || out_valid_o !== 1'b0 || sel_o !== 2'd0) begin
         n_err++;
         $display("FAIL midrst_async: got gnt=%b busy=%b valid=%b sel=%0d want 0000/0/0/0",
                  gnt_o, busy_o, out_valid_o, sel_o);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      req_i = 4'b0100;
      for (int c = 0; c < 2; c++) begin
         #1;
         n_vec++;
         if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL midrst_post c%0d: got %h want %h", c, obs_vec(), exp_vec());
         end
         if (c == 1) begin
            n_vec++;
            if (gnt_o !== 4'b0100 || sel_o !== 2'd2) begin
               n_err++;
               $display("FAIL midrst_regrant: got gnt=%b sel=%0d want 0100/2", gnt_o, sel_o);
            end
         end
         tick();
      end
   endtask

   task automatic test_prio0();
      logic [3:0] reqs[4] = '{4'b0010, 4'b0000, 4'b0101, 4'b0101};
`ifdef MUX4_SCHED_PRIO0_EN
      logic [1:0] want = 2'd0;
`else
      logic [1:0] want = 2'd2;
`endif
      apply_reset();
      out_ready_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         req_i  = reqs[c];
         data_i = $urandom;
         #1;
         n_vec++;
         if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL prio0 c%0d: got %h want %h", c, obs_vec(), exp_vec());
         end
         if (c == 3) begin
            n_vec++;
            if (sel_o !== want || busy_o !== 1'b1) begin
               n_err++;
               $display("FAIL prio0_pick: got sel=%0d busy=%b want %0d/1", sel_o, busy_o, want);
            end
         end
         tick();
      end
   endtask

   task automatic test_random();
      apply_reset();
      req_i = 4'($urandom);
      for (int c = 0; c < 600; c++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 5) == 0) req_i[b] = ~req_i[b];
         end
         out_ready_i = ($urandom_range(0, 3) != 0);
         data_i      = $urandom;
         #1;
         n_vec++;
         if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL random c%0d: got %h want %h (req=%b rdy=%b)",
                     c, obs_vec(), exp_vec(), req_i, out_ready_i);
         end
         tick();
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_rotation();
      test_early_release();
      test_backpressure();
      test_reset_mid_burst();
      test_prio0();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
